// File: rtl/vp_batch_ctrl.sv
// Batch launcher for the vector processor: accepts one batch command, runs the VP
// once per iteration and advances the operand pointers by their strides between runs.
module vp_batch_ctrl #(
    parameter int unsigned SCALAR_WIDTH = 64,
    parameter int unsigned ITER_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_cmd_vld,
    output logic                    o_cmd_rdy,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_src0_ptr,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_src1_ptr,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_rslt_ptr,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_ksk_ptr,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_src0_stride,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_src1_stride,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_rslt_stride,
    input  logic [SCALAR_WIDTH-1:0] i_cmd_step,
    input  logic [ITER_WIDTH-1:0]   i_cmd_iter,
    input  logic                    i_abort,
    output logic                    o_start_vp,
    input  logic                    i_done_vp,
    output logic [SCALAR_WIDTH-1:0] o_csr_vp_src0_ptr,
    output logic [SCALAR_WIDTH-1:0] o_csr_vp_src1_ptr,
    output logic [SCALAR_WIDTH-1:0] o_csr_vp_rslt_ptr,
    output logic [SCALAR_WIDTH-1:0] o_csr_vp_ksk_ptr,
    output logic [SCALAR_WIDTH-1:0] o_csr_vp_step,
    output logic                    o_busy,
    output logic [ITER_WIDTH-1:0]   o_iter_idx,
    output logic                    o_done,
    output logic                    o_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_e;

    state_e                  state_q,       state_d;
    logic [SCALAR_WIDTH-1:0] src0_ptr_q,    src0_ptr_d;
    logic [SCALAR_WIDTH-1:0] src1_ptr_q,    src1_ptr_d;
    logic [SCALAR_WIDTH-1:0] rslt_ptr_q,    rslt_ptr_d;
    logic [SCALAR_WIDTH-1:0] ksk_ptr_q,     ksk_ptr_d;
    logic [SCALAR_WIDTH-1:0] step_q,        step_d;
    logic [SCALAR_WIDTH-1:0] src0_stride_q, src0_stride_d;
    logic [SCALAR_WIDTH-1:0] src1_stride_q, src1_stride_d;
    logic [SCALAR_WIDTH-1:0] rslt_stride_q, rslt_stride_d;
    logic [ITER_WIDTH-1:0]   iter_q,        iter_d;
    logic [ITER_WIDTH-1:0]   iter_idx_q,    iter_idx_d;
    logic                    abort_q,       abort_d;
    logic                    last_run;

    // iter_q is never zero while in WAIT, so iter_q - 1 cannot underflow there.
    assign last_run = (iter_idx_q == iter_q - ITER_WIDTH'(1));

    always_comb begin
        state_d       = state_q;
        src0_ptr_d    = src0_ptr_q;
        src1_ptr_d    = src1_ptr_q;
        rslt_ptr_d    = rslt_ptr_q;
        ksk_ptr_d     = ksk_ptr_q;
        step_d        = step_q;
        src0_stride_d = src0_stride_q;
        src1_stride_d = src1_stride_q;
        rslt_stride_d = rslt_stride_q;
        iter_d        = iter_q;
        iter_idx_d    = iter_idx_q;
        abort_d       = abort_q;

        if (state_q != S_IDLE && i_abort) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_vld) begin
                    src0_ptr_d    = i_cmd_src0_ptr;
                    src1_ptr_d    = i_cmd_src1_ptr;
                    rslt_ptr_d    = i_cmd_rslt_ptr;
                    ksk_ptr_d     = i_cmd_ksk_ptr;
                    step_d        = i_cmd_step;
                    src0_stride_d = i_cmd_src0_stride;
                    src1_stride_d = i_cmd_src1_stride;
                    rslt_stride_d = i_cmd_rslt_stride;
                    iter_d        = i_cmd_iter;
                    iter_idx_d    = '0;
                    abort_d       = 1'b0;
                    state_d       = (i_cmd_iter == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_done_vp) begin
                    state_d = (last_run || abort_q) ? S_FINISH : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                src0_ptr_d = src0_ptr_q + src0_stride_q;
                src1_ptr_d = src1_ptr_q + src1_stride_q;
                rslt_ptr_d = rslt_ptr_q + rslt_stride_q;
                iter_idx_d = iter_idx_q + ITER_WIDTH'(1);
                state_d    = S_LAUNCH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            src0_ptr_q    <= '0;
            src1_ptr_q    <= '0;
            rslt_ptr_q    <= '0;
            ksk_ptr_q     <= '0;
            step_q        <= '0;
            src0_stride_q <= '0;
            src1_stride_q <= '0;
            rslt_stride_q <= '0;
            iter_q        <= '0;
            iter_idx_q    <= '0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            src0_ptr_q    <= src0_ptr_d;
            src1_ptr_q    <= src1_ptr_d;
            rslt_ptr_q    <= rslt_ptr_d;
            ksk_ptr_q     <= ksk_ptr_d;
            step_q        <= step_d;
            src0_stride_q <= src0_stride_d;
            src1_stride_q <= src1_stride_d;
            rslt_stride_q <= rslt_stride_d;
            iter_q        <= iter_d;
            iter_idx_q    <= iter_idx_d;
            abort_q       <= abort_d;
        end
    end

    assign o_cmd_rdy         = (state_q == S_IDLE);
    assign o_busy            = (state_q != S_IDLE);
    assign o_start_vp        = (state_q == S_LAUNCH);
    assign o_done            = (state_q == S_FINISH);
    assign o_aborted         = (state_q == S_FINISH) && abort_q;
    assign o_iter_idx        = iter_idx_q;
    assign o_csr_vp_src0_ptr = src0_ptr_q;
    assign o_csr_vp_src1_ptr = src1_ptr_q;
    assign o_csr_vp_rslt_ptr = rslt_ptr_q;
    assign o_csr_vp_ksk_ptr  = ksk_ptr_q;
    assign o_csr_vp_step     = step_q;

endmodule
